// File: rtl/graphic_update_scheduler.sv
// graphic_update_scheduler: vblank-gated sprite command FIFO; optional sticky OVERFLOW via GRAPHIC_SCHED_OVF_EN
module graphic_update_scheduler #(
    parameter int N_SPRITES = 16,
    parameter int DEPTH     = 8,
    parameter int V_ACTIVE  = 480,
    parameter int IW        = $clog2(N_SPRITES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CPU_WE,
    input  logic [IW-1:0]        CPU_INDEX,
    input  logic [31:0]          CPU_DATA,
    output logic                 CPU_FULL,
    input  logic [9:0]           SYS_Y,
    output logic [N_SPRITES-1:0] WRITE,
    output logic [31:0]          WRITE_DATA,
    output logic                 PENDING,
    output logic                 FRAME_COMMIT,
    output logic                 OVERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [N_SPRITES-1:0] ONE = N_SPRITES'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [IW+31:0]        mem_q [DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d, remain_q, remain_d;
    state_t                state_q, state_d;
    logic                  vblank, vblank_q, vb_edge, push, pop;
    logic [IW-1:0]         head_idx;
    logic [31:0]           head_data;
    logic [N_SPRITES-1:0]  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  commit_q, commit_d, pending_q, pending_d, full_q, full_d;

    // Next-state: FIFO bookkeeping, batch snapshot on the vblank edge, one pop per cycle while draining
    always_comb begin
        vblank    = SYS_Y >= 10'(V_ACTIVE);
        vb_edge   = vblank && !vblank_q;
        push      = CPU_WE && (cnt_q != CW'(DEPTH));
        pop       = state_q == DRAIN;
        {head_idx, head_data} = mem_q[rd_q];
        wr_d      = push ? wr_q + AW'(1) : wr_q;
        rd_d      = pop ? rd_q + AW'(1) : rd_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        state_d   = pop ? (remain_q == CW'(1) ? IDLE : DRAIN)
                        : ((vb_edge && cnt_q != '0) ? DRAIN : IDLE);
        remain_d  = pop ? remain_q - CW'(1) : (vb_edge ? cnt_q : remain_q);
        write_d   = (pop && int'(head_idx) < N_SPRITES) ? ONE << head_idx : '0;
        wdata_d   = pop ? head_data : wdata_q;
        commit_d  = pop && remain_q == CW'(1);
        pending_d = cnt_d != '0;
        full_d    = cnt_d == CW'(DEPTH);
    end

    // Control state and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            remain_q  <= '0;
            state_q   <= IDLE;
            vblank_q  <= 1'b0;
            write_q   <= '0;
            wdata_q   <= '0;
            commit_q  <= 1'b0;
            pending_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            remain_q  <= remain_d;
            state_q   <= state_d;
            vblank_q  <= vblank;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            commit_q  <= commit_d;
            pending_q <= pending_d;
            full_q    <= full_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers do
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= {CPU_INDEX, CPU_DATA};
    end

`ifdef GRAPHIC_SCHED_OVF_EN
    logic ovf_q;
    // Sticky flag for writes dropped against a full FIFO
    always_ff @(posedge CLK) begin
        if (RST) ovf_q <= 1'b0;
        else if (CPU_WE && cnt_q == CW'(DEPTH)) ovf_q <= 1'b1;
    end
    assign OVERFLOW = ovf_q;
`else
    assign OVERFLOW = 1'b0;
`endif

    assign WRITE        = write_q;
    assign WRITE_DATA   = wdata_q;
    assign FRAME_COMMIT = commit_q;
    assign PENDING      = pending_q;
    assign CPU_FULL     = full_q;
endmodule

// File: tb/tb_graphic_update_scheduler.sv
// tb_graphic_update_scheduler: directed and random checks against a queue-based reference model
module tb_graphic_update_scheduler;
    logic        clk = 1'b0;
    logic        rst, cpu_we, cpu_full, pending, frame_commit, overflow;
    logic [4:0]  cpu_index;
    logic [31:0] cpu_data, write_data;
    logic [9:0]  sys_y;
    logic [15:0] write;

    graphic_update_scheduler #(.N_SPRITES(16), .DEPTH(8), .V_ACTIVE(480), .IW(5)) dut (
        .CLK(clk), .RST(rst), .CPU_WE(cpu_we), .CPU_INDEX(cpu_index), .CPU_DATA(cpu_data),
        .CPU_FULL(cpu_full), .SYS_Y(sys_y), .WRITE(write), .WRITE_DATA(write_data),
        .PENDING(pending), .FRAME_COMMIT(frame_commit), .OVERFLOW(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          batch = 0;
    bit          vbprev = 0;
    logic [15:0] exp_write = '0;
    logic [31:0] exp_wdata = '0;
    bit          exp_commit = 0, exp_ovf = 0;
    int          checks = 0, failures = 0, nwr = 0, ncommit = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clk();
        bit vb, edge_now, full_pre;
        ent_t e;
        logic [15:0] one = 16'h1;
        if (rst) begin
            q.delete();
            batch = 0; vbprev = 0; exp_write = '0; exp_wdata = '0; exp_commit = 0; exp_ovf = 0;
            return;
        end
        vb = sys_y >= 10'd480;
        edge_now = vb && !vbprev;
        vbprev = vb;
        full_pre = q.size() == 8;
        if (cpu_we && full_pre) exp_ovf = 1;
        exp_write = '0;
        exp_commit = 0;
        if (batch > 0) begin
            e = q.pop_front();
            exp_write = (e.idx < 16) ? (one << e.idx) : 16'h0;
            exp_wdata = e.d;
            batch--;
            exp_commit = batch == 0;
        end else if (edge_now) begin
            batch = q.size();
        end
        if (cpu_we && !full_pre) q.push_back('{cpu_index, cpu_data});
    endtask

    task automatic step(input logic we, input logic [4:0] idx, input logic [31:0] d);
        cpu_we = we; cpu_index = idx; cpu_data = d;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        chk("write", write, exp_write);
        chk("write_data", write_data, exp_wdata);
        chk("frame_commit", frame_commit, exp_commit);
        chk("pending", pending, q.size() > 0);
        chk("cpu_full", cpu_full, q.size() == 8);
`ifdef GRAPHIC_SCHED_OVF_EN
        chk("overflow", overflow, exp_ovf);
`else
        chk("overflow", overflow, 0);
`endif
        if (write != 0) nwr++;
        if (frame_commit) ncommit++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        bit vbr;
        rst = 1; sys_y = 100;
        idle(2);
        rst = 0;
        chk("rst_write", write, 0);
        chk("rst_pending", pending, 0);
        // three-entry batch
        step(1, 0, 32'h1234_5000);
        step(1, 5, 32'h0A00_0001);
        step(1, 15, 32'hFFFF_FFFF);
        idle(1);
        sys_y = 479; idle(1);
        sys_y = 480; nwr = 0; ncommit = 0;
        idle(1);
        chk("t1_edge_write", write, 0);
        idle(1);
        chk("t1_w0", write, 16'h0001); chk("t1_d0", write_data, 32'h1234_5000); chk("t1_c0", frame_commit, 0);
        idle(1);
        chk("t1_w1", write, 16'h0020); chk("t1_d1", write_data, 32'h0A00_0001); chk("t1_c1", frame_commit, 0);
        idle(1);
        chk("t1_w2", write, 16'h8000); chk("t1_d2", write_data, 32'hFFFF_FFFF); chk("t1_c2", frame_commit, 1);
        idle(2);
        chk("t1_nwr", nwr, 3); chk("t1_ncommit", ncommit, 1);
        // fill, overflow, full drain
        sys_y = 100; idle(1);
        for (int i = 0; i < 8; i++) step(1, 5'($urandom_range(0, 15)), $urandom);
        chk("t2_full", cpu_full, 1);
        step(1, 3, 32'hDEAD_BEEF);
        chk("t2_full_still", cpu_full, 1);
`ifdef GRAPHIC_SCHED_OVF_EN
        chk("t2_ovf", overflow, 1);
`else
        chk("t2_ovf", overflow, 0);
`endif
        sys_y = 480; nwr = 0;
        idle(12);
        chk("t2_nwr", nwr, 8);
        // push during drain waits for next frame
        sys_y = 100; idle(1);
        step(1, 1, 32'hA);
        step(1, 2, 32'hB);
        sys_y = 480; nwr = 0;
        idle(1);
        step(1, 4, 32'hC);
        idle(3);
        chk("t3_nwr", nwr, 2); chk("t3_pending", pending, 1);
        sys_y = 100; idle(3);
        chk("t3_pending_between", pending, 1);
        sys_y = 480; nwr = 0; idle(3);
        chk("t3_nwr_next", nwr, 1); chk("t3_write_data", write_data, 32'hC); chk("t3_empty", pending, 0);
        // empty edge and no re-trigger while vblank held
        sys_y = 100; idle(1);
        sys_y = 500; nwr = 0; ncommit = 0;
        idle(10);
        step(1, 7, 32'h77);
        idle(10);
        chk("t4_nwr", nwr, 0); chk("t4_ncommit", ncommit, 0); chk("t4_pending", pending, 1);
        sys_y = 100; idle(1);
        sys_y = 480; idle(3);
        // reset mid-drain
        sys_y = 100; idle(1);
        for (int i = 0; i < 4; i++) step(1, 5'(i + 8), 32'h100 + i);
        sys_y = 480;
        idle(3);
        chk("t5_w2", write, 16'h0200);
        rst = 1; idle(1); rst = 0;
        chk("t5_write", write, 0); chk("t5_pending", pending, 0); chk("t5_commit", frame_commit, 0);
        nwr = 0; idle(6);
        chk("t5_nwr", nwr, 0);
        // out-of-range index
        sys_y = 100; idle(1);
        step(1, 2, 32'h11);
        step(1, 16, 32'hCAFE_0016);
        sys_y = 480; idle(2);
        chk("t6_w0", write, 16'h0004);
        idle(1);
        chk("t6_w1", write, 0); chk("t6_d1", write_data, 32'hCAFE_0016); chk("t6_c1", frame_commit, 1);
        // random traffic
        vbr = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) vbr = !vbr;
            sys_y = vbr ? 10'($urandom_range(480, 524)) : 10'($urandom_range(0, 479));
            rst = $urandom_range(0, 299) == 0;
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 17)), $urandom);
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/graphic_update_scheduler.md
# graphic_update_scheduler

Frame-coherent command queue between the CPU's memory-mapped sprite writes and the bank of graphic register stages. CPU writes (sprite index + 32-bit sprite word) are buffered in a FIFO and released to the graphic registers only during vertical blanking, one per clock, so no sprite moves mid-frame. Each released entry drives one one-hot WRITE strobe plus the shared WRITE_DATA bus consumed by the per-sprite graphic register stages.

## Interface
Parameters:
- N_SPRITES, 16, number of downstream graphic register stages; index width IW = $clog2(N_SPRITES)
- DEPTH, 8, FIFO entries (power of 2, 2..64); must be ≤ vblank length in clocks
- V_ACTIVE, 480, first SYS_Y value considered vertical blank

Ports (clock is CLK; reset is RST, synchronous, active-high):
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- CPU_WE  in  1  push request
- CPU_INDEX  in  IW  target sprite stage
- CPU_DATA  in  32  sprite word {Y[31:22], X[21:12], image[11:6], attr[5:0]}
- CPU_FULL  out  1  FIFO occupancy == DEPTH
- SYS_Y  in  10  current raster line from the video timing generator
- WRITE  out  N_SPRITES  one-hot write strobe to graphic register stages
- WRITE_DATA  out  32  data for the strobed stage
- PENDING  out  1  FIFO non-empty
- FRAME_COMMIT  out  1  one-cycle pulse with the last WRITE of a batch
- OVERFLOW  out  1  sticky dropped-write flag (only with GRAPHIC_SCHED_OVF_EN)

## Operation
- FIFO entry = {CPU_INDEX, CPU_DATA}; push when CPU_WE && !CPU_FULL. CPU_WE while CPU_FULL: write dropped, FIFO unchanged.
- Push and pop in the same cycle allowed; CPU_FULL is evaluated on pre-pop occupancy (a push while full is rejected even if a pop occurs that cycle).
- VBLANK = (SYS_Y >= V_ACTIVE); VBLANK_Q = registered VBLANK; VB_EDGE = VBLANK && !VBLANK_Q.
- States:
  - IDLE: WRITE = 0. On VB_EDGE with occupancy > 0: REMAIN <= occupancy (snapshot), go DRAIN. On VB_EDGE with occupancy 0: stay IDLE, no FRAME_COMMIT.
  - DRAIN: pop head each cycle; register WRITE = one-hot(index), WRITE_DATA = data; REMAIN--. When the popped entry is the last (REMAIN == 1): FRAME_COMMIT registered high alongside that WRITE, go IDLE.
- Entries pushed after VB_EDGE (including during DRAIN) are not part of the batch; they wait for the next VB_EDGE.
- DRAIN runs to completion even if VBLANK deasserts (batch atomicity).
- CPU_INDEX ≥ N_SPRITES: entry is queued and popped normally, but WRITE stays all-zero for that slot; WRITE_DATA is still updated and FRAME_COMMIT still counts it.
- FIFO pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.

## Timing
- Reset values: WRITE 0, WRITE_DATA 0, CPU_FULL 0, PENDING 0, FRAME_COMMIT 0, OVERFLOW 0, state IDLE, FIFO empty, VBLANK_Q 0.
- Edge E: first clock edge sampling SYS_Y ≥ V_ACTIVE with VBLANK_Q = 0 → state DRAIN after E.
- First pop at edge E+1; WRITE/WRITE_DATA visible after E+1 and held for exactly one cycle per entry; batch of K entries occupies K consecutive cycles, with FRAME_COMMIT coincident with the K-th WRITE.
- PENDING and CPU_FULL are registered from occupancy and reflect a push one cycle after the accepting edge.
- RST mid-DRAIN: FIFO flushed, WRITE/FRAME_COMMIT 0 on the next cycle, state IDLE. Already-strobed stages keep their new values (partial batch accepted).
- Reset held across a VB_EDGE: no drain occurs; VBLANK_Q tracks VBLANK only after reset releases (starts at 0), so releasing reset inside vblank produces a VB_EDGE one cycle later.

## Configuration
- GRAPHIC_SCHED_OVF_EN defined: OVERFLOW is set on any CPU_WE while CPU_FULL and stays set until RST.
- Not defined: OVERFLOW port tied to 0, no flag register; dropped writes are silent.

## Test plan
- Push 3 entries (idx 0,5,15; data 0x1234_5000, 0x0A00_0001, 0xFFFF_FFFF) with SYS_Y = 100, then step SYS_Y to 480 → WRITE = 0x0001, 0x0020, 0x8000 on 3 consecutive cycles starting 2 cycles after the edge, matching data; FRAME_COMMIT only with the third.
- Push 8 entries with DEPTH = 8, then a 9th → CPU_FULL = 1, 9th dropped, OVERFLOW = 1 (macro on) / 0 (macro off); drain yields exactly 8 WRITEs.
- Push 2 entries, raise vblank, push 1 more during DRAIN → only 2 WRITEs this frame; third released at the next vblank edge; PENDING stays 1 between frames.
- Vblank edge with empty FIFO → WRITE stays 0, no FRAME_COMMIT; SYS_Y held at 500 for many cycles with a push in the middle → no drain until the next edge.
- RST asserted after the 2nd of 4 WRITEs → WRITE 0 next cycle, PENDING 0, next vblank produces no WRITE.
- Entry with CPU_INDEX = 16 at N_SPRITES = 16 (IW widened to 5) → WRITE all-zero for that slot; batch FRAME_COMMIT still asserts on the final entry.
